// File: rtl/input_conditioner.sv
// Player-control conditioner: synchronise, debounce, merge with keyboard,
// clean opposing directions, stretch coin and track the scanline combo.
module input_conditioner #(
   parameter int DEB_BITS    = 16,
   parameter int COIN_CYCLES = 800000
) (
   input  logic       clk_i,
   input  logic       res_n_i,
   input  logic [5:0] joy_n_i,
   input  logic [2:0] btn_n_i,
   input  logic [8:0] kbd_i,
   output logic [8:0] ctl_o,
   output logic [1:0] scan_o
);

   localparam int HOLD_W = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(COIN_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
   localparam logic [DEB_BITS-1:0] DEB_MAX   = '1;
   localparam logic [DEB_BITS-1:0] DEB_ONE   = DEB_BITS'(1);

   logic [8:0]          w_raw_n;
   logic [8:0]          r_sync1;
   logic [8:0]          r_sync2;
   logic [8:0]          r_stable;
   logic [DEB_BITS-1:0] r_cnt [9];
   logic [8:0]          w_phys;
   logic [8:0]          w_m;
   logic                w_combo;
   logic                w_combo_rise;
   logic                w_coin_rise;
   logic                r_coin_prev;
   logic                r_combo_prev;
   logic                r_hold_act;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [1:0]          r_scan;
   logic [8:0]          r_ctl;
   logic [8:0]          w_ctl_d;

   assign w_raw_n = {joy_n_i[5], btn_n_i[2], btn_n_i[1], btn_n_i[0],
                     joy_n_i[4], joy_n_i[3:0]};

   // Two-flop synchroniser and per-bit debounce, kept in raw active-low sense.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_sync1  <= 9'h1FF;
         r_sync2  <= 9'h1FF;
         r_stable <= 9'h1FF;
         for (int i = 0; i < 9; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= w_raw_n;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 9; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == DEB_MAX) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i]    <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + DEB_ONE;
            end
         end
      end
   end

   assign w_phys       = ~r_stable;
   assign w_m          = w_phys | kbd_i;
   assign w_combo      = w_phys[5] & w_phys[6];
   assign w_combo_rise = w_combo & ~r_combo_prev;
   assign w_coin_rise  = w_m[7] & ~r_coin_prev;

   // Coin hold: the triggering clock is the first high clock, so load C-1.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_coin_prev <= 1'b0;
         r_hold_act  <= 1'b0;
         r_hold_cnt  <= '0;
      end else begin
         r_coin_prev <= w_m[7];
         if (r_hold_act) begin
            if (r_hold_cnt <= HOLD_ONE) begin
               r_hold_act <= 1'b0;
               r_hold_cnt <= '0;
            end else begin
               r_hold_cnt <= r_hold_cnt - HOLD_ONE;
            end
         end else if (w_coin_rise) begin
            r_hold_cnt <= HOLD_LOAD;
            r_hold_act <= (COIN_CYCLES > 1);
         end
      end
   end

   // Scanline mode advances on each rising edge of the physical start combo.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_combo_prev <= 1'b0;
         r_scan       <= 2'd0;
      end else begin
         r_combo_prev <= w_combo;
         if (w_combo_rise) begin
            r_scan <= r_scan + 2'd1;
         end
      end
   end

   // Next control word: opposing-direction cleanup, start masking, coin stretch.
   always_comb begin
      w_ctl_d    = w_m;
      w_ctl_d[7] = r_hold_act | w_m[7];
      if (w_m[0] & w_m[1]) begin
         w_ctl_d[1:0] = 2'b00;
      end else begin
         w_ctl_d[1:0] = w_m[1:0];
      end
      if (w_m[2] & w_m[3]) begin
         w_ctl_d[3:2] = 2'b00;
      end else begin
         w_ctl_d[3:2] = w_m[3:2];
      end
      if (w_combo) begin
         w_ctl_d[6:5] = 2'b00;
      end else begin
         w_ctl_d[6:5] = w_m[6:5];
      end
   end

   // Registered control output.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_ctl <= 9'h000;
      end else begin
         r_ctl <= w_ctl_d;
      end
   end

   assign ctl_o  = r_ctl;
   assign scan_o = r_scan;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed plus randomised bench for input_conditioner with a history-window
// reference model (DEB_BITS=2, COIN_CYCLES=5).
module tb_input_conditioner;

   localparam int DEB_BITS = 2;
   localparam int COIN     = 5;
   localparam int DEB_LEN  = 1 << DEB_BITS;

   logic       clk_i   = 1'b0;
   logic       res_n_i = 1'b0;
   logic [5:0] joy_n_i = 6'h3F;
   logic [2:0] btn_n_i = 3'h7;
   logic [8:0] kbd_i   = 9'h000;
   logic [8:0] ctl_o;
   logic [1:0] scan_o;

   int tests = 0;
   int fails = 0;

   // Reference model state: raw history per edge, debounced raw levels, coin window.
   logic [8:0] h [DEB_LEN + 2];
   logic [8:0] m_stab;
   logic       m_coin_prev;
   logic       m_combo_prev;
   int         m_until;
   int         m_edge = 0;
   int         m_scan;
   logic [8:0] exp_ctl;
   logic [1:0] exp_scan;

   input_conditioner #(.DEB_BITS(DEB_BITS), .COIN_CYCLES(COIN)) dut (
      .clk_i  (clk_i),
      .res_n_i(res_n_i),
      .joy_n_i(joy_n_i),
      .btn_n_i(btn_n_i),
      .kbd_i  (kbd_i),
      .ctl_o  (ctl_o),
      .scan_o (scan_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [8:0] raw_vec();
      return {joy_n_i[5], btn_n_i[2], btn_n_i[1], btn_n_i[0], joy_n_i[4], joy_n_i[3:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < DEB_LEN + 2; j++) h[j] = 9'h1FF;
      m_stab       = 9'h1FF;
      m_coin_prev  = 1'b0;
      m_combo_prev = 1'b0;
      m_until      = -1;
      m_scan       = 0;
      exp_ctl      = 9'h000;
      exp_scan     = 2'd0;
   endtask

   // A physical level is accepted once its synchronised copy (raw two edges
   // back) has shown the same new value on DEB_LEN consecutive edges.
   task automatic model_edge();
      logic [8:0] phys, m, nxt;
      logic       combo, coin, same;
      m_edge++;
      phys  = ~m_stab;
      m     = phys | kbd_i;
      combo = phys[5] & phys[6];
      if (m[7] && !m_coin_prev && m_edge > m_until) m_until = m_edge + COIN - 1;
      coin        = m[7] || (m_edge <= m_until);
      m_coin_prev = m[7];
      if (combo && !m_combo_prev) m_scan = (m_scan + 1) % 4;
      m_combo_prev = combo;
      nxt = m;
      if (m[0] && m[1]) nxt[1:0] = 2'b00;
      if (m[2] && m[3]) nxt[3:2] = 2'b00;
      if (combo) nxt[6:5] = 2'b00;
      nxt[7]   = coin;
      exp_ctl  = nxt;
      exp_scan = 2'(m_scan);
      for (int j = DEB_LEN + 1; j > 0; j--) h[j] = h[j-1];
      h[0] = raw_vec();
      for (int b = 0; b < 9; b++) begin
         same = 1'b1;
         for (int j = 3; j < DEB_LEN + 2; j++) if (h[j][b] != h[2][b]) same = 1'b0;
         if (same && h[2][b] != m_stab[b]) m_stab[b] = h[2][b];
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
      chk("ctl", 32'(ctl_o), 32'(exp_ctl));
      chk("scan", 32'(scan_o), 32'(exp_scan));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int first;
      int cnt;

      // 1. reset and idle
      model_reset();
      #12 res_n_i = 1'b1;
      ticks(20);
      chk("idle_ctl", 32'(ctl_o), 32'h0);
      chk("idle_scan", 32'(scan_o), 32'h0);

      // 2. debounce latency and glitch rejection
      joy_n_i[0] = 1'b0;
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (first < 0 && ctl_o[0]) first = i;
      end
      chk("deb_latency", 32'(first), 32'd7);
      joy_n_i[0] = 1'b1;
      ticks(10);
      joy_n_i[0] = 1'b0;
      ticks(3);
      joy_n_i[0] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         cnt += int'(ctl_o[0]);
      end
      chk("glitch", 32'(cnt), 32'd0);

      // 3. coin stretch: tap, no retrigger, long press
      kbd_i[7] = 1'b1;
      tick();
      kbd_i[7] = 1'b0;
      cnt = int'(ctl_o[7]);
      for (int i = 0; i < 11; i++) begin
         tick();
         cnt += int'(ctl_o[7]);
      end
      chk("coin_tap", 32'(cnt), 32'd5);
      kbd_i[7] = 1'b1;
      tick();
      cnt = int'(ctl_o[7]);
      kbd_i[7] = 1'b0;
      tick();
      cnt += int'(ctl_o[7]);
      kbd_i[7] = 1'b1;
      tick();
      cnt += int'(ctl_o[7]);
      kbd_i[7] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt += int'(ctl_o[7]);
      end
      chk("coin_noretrig", 32'(cnt), 32'd5);
      kbd_i[7] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         cnt += int'(ctl_o[7]);
      end
      kbd_i[7] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt += int'(ctl_o[7]);
      end
      chk("coin_long", 32'(cnt), 32'd20);

      // 1b. asynchronous reset in the middle of a coin hold
      kbd_i[7] = 1'b1;
      tick();
      kbd_i[7] = 1'b0;
      ticks(2);
      #2 res_n_i = 1'b0;
      #1 chk("rst_async", 32'(ctl_o), 32'h0);
      repeat (2) @(posedge clk_i);
      #2 res_n_i = 1'b1;
      model_reset();
      ticks(8);
      chk("rst_no_pulse", 32'(ctl_o), 32'h0);

      // 4. opposing-direction cleanup
      kbd_i[0]   = 1'b1;
      joy_n_i[1] = 1'b0;
      ticks(10);
      chk("socd_ud", 32'(ctl_o[1:0]), 32'h0);
      joy_n_i[1] = 1'b1;
      ticks(10);
      chk("socd_up_only", 32'(ctl_o[1:0]), 32'h1);
      kbd_i[3:0] = 4'b1101;
      ticks(2);
      chk("socd_lr", 32'(ctl_o[3:0]), 32'h1);
      kbd_i = 9'h000;
      ticks(3);

      // 5. scanline combo
      for (int r = 1; r <= 4; r++) begin
         btn_n_i[1:0] = 2'b00;
         ticks(10);
         chk("scan_step", 32'(scan_o), 32'(r % 4));
         chk("start_mask", 32'(ctl_o[6:5]), 32'h0);
         btn_n_i[1:0] = 2'b11;
         ticks(10);
      end
      btn_n_i[0] = 1'b0;
      ticks(10);
      chk("start1_alone", 32'(ctl_o[5]), 32'h1);
      chk("start1_scan", 32'(scan_o), 32'h0);
      btn_n_i[0] = 1'b1;
      ticks(10);

      // 6. keyboard start masked by combo, visible once combo releases
      kbd_i[6]     = 1'b1;
      btn_n_i[1:0] = 2'b00;
      ticks(10);
      chk("kbd_start_mask", 32'(ctl_o[6]), 32'h0);
      btn_n_i[1:0] = 2'b11;
      first = -1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (first < 0 && ctl_o[6]) first = i;
      end
      chk("kbd_start_release", 32'(first), 32'd7);
      kbd_i = 9'h000;
      ticks(10);

      // 7. random traffic against the model
      for (int n = 0; n < 800; n++) begin
         for (int b = 0; b < 6; b++) if ($urandom_range(0, 9) == 0) joy_n_i[b] = ~joy_n_i[b];
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) btn_n_i[b] = ~btn_n_i[b];
         if ($urandom_range(0, 4) == 0)
            kbd_i = 9'($urandom_range(0, 511)) & 9'($urandom_range(0, 511)) & 9'($urandom_range(0, 511));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
